memory: RTL and testbench

- Small synchronous word-addressed RAM with independent write ("in") and read ("out") request channels.
- Each channel uses a valid/ready handshake: one request is accepted per two cycles, and completion is signalled by a one-cycle ready pulse.
- Used as a simple backing store for CPU-core simulation and bring-up.
- Byte addresses are 32-bit; only the word-index bits select a location, so higher bits alias.

---
 rtl/memory_pkg.sv | 26 ++
 rtl/mem_handshake.sv | 41 ++++
 rtl/memory.sv | 90 +++++++++
 tb/tb_memory.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared constants and helpers for the word-addressed backing-store RAM.
//   DATA_WIDTH       : width of one stored word
//   ADDR_BITS        : width of the byte address presented on each channel
//   BYTE_OFFSET_BITS : low address bits that select a byte within a word
//   word_index()     : byte address -> word index for a given index width
// -----------------------------------------------------------------------------
package memory_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned ADDR_BITS        = 32;
  localparam int unsigned BYTE_OFFSET_BITS = 2;

  // Drops the byte offset and masks off everything above the index, so any
  // two addresses that differ only in those bits map to the same word.
  function automatic logic [ADDR_BITS-1:0] word_index(
    input logic [ADDR_BITS-1:0] addr,
    input int unsigned          addr_width
  );
    logic [ADDR_BITS-1:0] mask;
    mask = (ADDR_BITS'(1) << addr_width) - ADDR_BITS'(1);
    return (addr >> BYTE_OFFSET_BITS) & mask;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// -----------------------------------------------------------------------------
// mem_handshake
// Valid/ready handshake for one request channel. A request is accepted on
// any edge where valid is high and ready is low; ready then pulses for one
// cycle. Holding valid high therefore yields ready = 1,0,1,0,...
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   valid  : request present
//   ready  : one-cycle completion pulse (registered)
//   accept : combinational strobe, high in the cycle whose closing edge
//            accepts the request (used by the datapath as a write/read enable)
// -----------------------------------------------------------------------------
module mem_handshake (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  output logic ready,
  output logic accept
);

  logic ready_q;
  logic ready_d;

  always_comb begin
    accept  = valid & ~ready_q;
    ready_d = accept;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
// Small synchronous word-addressed RAM with independent write ("in") and read
// ("out") channels, each with its own valid/ready handshake.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high; clears readies, out_data and storage
//   in_addr   : write byte address (only the word-index bits are used)
//   in_data   : write data
//   in_valid  : write request
//   in_ready  : write-complete pulse
//   out_addr  : read byte address (only the word-index bits are used)
//   out_valid : read request
//   out_ready : read-complete pulse; out_data is valid while it is high
//   out_data  : read data, holds its last value between reads
// -----------------------------------------------------------------------------
module memory
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_BITS-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_BITS-1:0]  out_addr,
  input  logic                  out_valid,
  output logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  in_accept;
  logic                  out_accept;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] out_data_d;

  mem_handshake u_in_hs (
    .clk    (clk),
    .reset  (reset),
    .valid  (in_valid),
    .ready  (in_ready),
    .accept (in_accept)
  );

  mem_handshake u_out_hs (
    .clk    (clk),
    .reset  (reset),
    .valid  (out_valid),
    .ready  (out_ready),
    .accept (out_accept)
  );

  always_comb begin
    wr_idx     = ADDR_WIDTH'(word_index(in_addr, ADDR_WIDTH));
    rd_idx     = ADDR_WIDTH'(word_index(out_addr, ADDR_WIDTH));
    // The read takes the array's pre-edge contents, so a write to the same
    // word on the same edge is not visible until the next read.
    out_data_d = out_data_q;
    if (out_accept) begin
      out_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      // NOTE: clearing the storage on reset forces it into flops rather than a
      // RAM macro; acceptable here because the array is tiny and a known-zero
      // memory after reset is part of the contract.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      out_data_q <= out_data_d;
      if (in_accept) begin
        mem_q[wr_idx] <= in_data;
      end
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_memory.sv
// -----------------------------------------------------------------------------
// tb_memory
// Self-checking bench for memory. A reference model built from the behavioural
// description predicts handshake outputs; expected read data is queued when a
// read is accepted and popped when the DUT raises out_ready.
// -----------------------------------------------------------------------------
module tb_memory;

  localparam int unsigned AW = 5;

  logic        clk;
  logic        reset;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  memory #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] m_mem [32];
  logic        m_in_rdy;
  logic        m_out_rdy;
  logic [31:0] m_out_data;
  logic [31:0] sb_q [$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] widx(input logic [31:0] a);
    return a[6:2];
  endfunction

  // One clock cycle: drive at negedge, advance the model at posedge, compare
  // at the following negedge.
  task automatic tick(input logic iv, input logic [31:0] ia, input logic [31:0] id,
                      input logic ov, input logic [31:0] oa, input logic rst);
    logic        wr_acc;
    logic        rd_acc;
    logic [31:0] exp_d;
    reset     = rst;
    in_valid  = iv;
    in_addr   = ia;
    in_data   = id;
    out_valid = ov;
    out_addr  = oa;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_in_rdy   = 1'b0;
      m_out_rdy  = 1'b0;
      m_out_data = '0;
      sb_q.delete();
    end else begin
      wr_acc = iv & ~m_in_rdy;
      rd_acc = ov & ~m_out_rdy;
      if (rd_acc) begin
        m_out_data = m_mem[widx(oa)];
        sb_q.push_back(m_out_data);
      end
      if (wr_acc) m_mem[widx(ia)] = id;
      m_in_rdy  = wr_acc;
      m_out_rdy = rd_acc;
    end
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(m_in_rdy));
    check("out_ready", 32'(out_ready), 32'(m_out_rdy));
    check("out_data_hold", out_data, m_out_data);
    if (out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(out_ready), 32'd0);
      end else begin
        exp_d = sb_q.pop_front();
        check("rd_data", out_data, exp_d);
        last_rd = out_data;
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    last_rd = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 'x;
    m_in_rdy = 1'b0; m_out_rdy = 1'b0; m_out_data = '0;
    reset = 1'b1; in_valid = 1'b0; out_valid = 1'b0;
    in_addr = '0; in_data = '0; out_addr = '0;
    @(negedge clk);

    // Reset for two cycles
    tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_data", out_data, 32'd0);

    // Single write, valid for one cycle
    tick(1'b1, 32'd36, 32'hefefefef, 1'b0, '0, 1'b0);
    check("wr36_ready", 32'(in_ready), 32'd1);
    idle();
    check("wr36_ready_drop", 32'(in_ready), 32'd0);

    // Back-to-back writes with valid held: ready 1,0,1
    tick(1'b1, 32'd40, 32'hc3c3c3c3, 1'b0, '0, 1'b0);
    check("b2b_r0", 32'(in_ready), 32'd1);
    tick(1'b1, 32'd32, 32'h00000000, 1'b0, '0, 1'b0);
    check("b2b_r1", 32'(in_ready), 32'd0);
    tick(1'b1, 32'd32, 32'h00000000, 1'b0, '0, 1'b0);
    check("b2b_r2", 32'(in_ready), 32'd1);
    idle();

    // Reads: 40, idle, 36, then 32 with valid held
    tick(1'b0, '0, '0, 1'b1, 32'd40, 1'b0);
    check("rd40", last_rd, 32'hc3c3c3c3);
    idle();
    check("rd_idle_ready", 32'(out_ready), 32'd0);
    tick(1'b0, '0, '0, 1'b1, 32'd36, 1'b0);
    check("rd36", last_rd, 32'hefefefef);
    tick(1'b0, '0, '0, 1'b1, 32'd32, 1'b0);
    check("rd32_gap", 32'(out_ready), 32'd0);
    tick(1'b0, '0, '0, 1'b1, 32'd32, 1'b0);
    check("rd32_ready", 32'(out_ready), 32'd1);
    check("rd32", out_data, 32'h00000000);
    idle();

    // Aliasing: 0xf010 maps onto the same word as 0x10
    tick(1'b1, 32'h10, 32'h87654321, 1'b0, '0, 1'b0);
    idle();
    tick(1'b1, 32'hf010, 32'h12345678, 1'b0, '0, 1'b0);
    tick(1'b1, 32'hf010, 32'h12345678, 1'b0, '0, 1'b0);
    idle();
    tick(1'b0, '0, '0, 1'b1, 32'h10, 1'b0);
    check("alias_rd", last_rd, 32'h12345678);
    idle();

    // Byte offset ignored
    tick(1'b1, 32'h11, 32'h87654321, 1'b0, '0, 1'b0);
    idle();
    tick(1'b0, '0, '0, 1'b1, 32'h10, 1'b0);
    check("offset_rd", last_rd, 32'h87654321);
    idle();

    // Same-word read and write on one edge: read sees old contents
    tick(1'b1, 32'h20, 32'h11111111, 1'b0, '0, 1'b0);
    idle();
    tick(1'b1, 32'h20, 32'h22222222, 1'b1, 32'h20, 1'b0);
    check("rbw_old", last_rd, 32'h11111111);
    idle();
    tick(1'b0, '0, '0, 1'b1, 32'h20, 1'b0);
    check("rbw_new", last_rd, 32'h22222222);
    idle();

    // Random traffic over a small address window
    for (int k = 0; k < 40; k++) begin
      tick(1'($urandom_range(0, 1)), {$urandom_range(0, 3), 5'($urandom()), 2'($urandom())},
           $urandom(), 1'($urandom_range(0, 1)),
           {$urandom_range(0, 3), 5'($urandom()), 2'($urandom())}, 1'b0);
    end
    idle();

    // Reset during an active handshake
    tick(1'b1, 32'h4, 32'hdeadbeef, 1'b1, 32'h20, 1'b0);
    tick(1'b1, 32'h4, 32'hdeadbeef, 1'b1, 32'h20, 1'b1);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    check("rst_mid_out_ready", 32'(out_ready), 32'd0);
    check("rst_mid_out_data", out_data, 32'd0);
    tick(1'b0, '0, '0, 1'b1, 32'd36, 1'b0);
    check("post_rst_rd36", last_rd, 32'd0);
    idle();
    tick(1'b0, '0, '0, 1'b1, 32'd40, 1'b0);
    check("post_rst_rd40", last_rd, 32'd0);
    idle();
    tick(1'b0, '0, '0, 1'b1, 32'h20, 1'b0);
    check("post_rst_rd20", out_data, 32'd0);
    idle();

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
